// File: rtl/char_blitter_if.sv
// ---------------------------------------------------------------------------
// char_blitter_if
// Bundles the three buses around the glyph blitter:
//   font loader : font_wr, font_addr[9:0], font_data[7:0]
//   command     : cmd_valid/cmd_ready handshake plus cmd_char, cmd_col,
//                 cmd_row, cmd_fg, cmd_bg, cmd_transparent
//   framebuffer : fb_wr/fb_ready handshake plus fb_addr[ADDR_W-1:0], fb_data
//   status      : busy, done (1-cycle), err (1-cycle)
// Modport slave is the blitter's view; master is the controller/sink side.
// ---------------------------------------------------------------------------
interface char_blitter_if #(
  parameter int ADDR_W = 32
);
  logic              font_wr;
  logic [9:0]        font_addr;
  logic [7:0]        font_data;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        cmd_char;
  logic [6:0]        cmd_col;
  logic [5:0]        cmd_row;
  logic [7:0]        cmd_fg;
  logic [7:0]        cmd_bg;
  logic              cmd_transparent;
  logic              fb_wr;
  logic [ADDR_W-1:0] fb_addr;
  logic [7:0]        fb_data;
  logic              fb_ready;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  font_wr, font_addr, font_data,
    input  cmd_valid, cmd_char, cmd_col, cmd_row, cmd_fg, cmd_bg, cmd_transparent,
    output cmd_ready,
    output fb_wr, fb_addr, fb_data,
    input  fb_ready,
    output busy, done, err
  );

  modport master (
    output font_wr, font_addr, font_data,
    output cmd_valid, cmd_char, cmd_col, cmd_row, cmd_fg, cmd_bg, cmd_transparent,
    input  cmd_ready,
    input  fb_wr, fb_addr, fb_data,
    output fb_ready,
    input  busy, done, err
  );
endinterface

// File: rtl/char_blitter.sv
// ---------------------------------------------------------------------------
// char_blitter
// Draws one font glyph into a text cell of the framebuffer, magnified by
// 2^(SCALE-1), with per-command fg/bg colours and optional transparency.
// Ports:
//   pclk   single clock
//   rst_n  asynchronous active-low reset
//   bus    char_blitter_if.slave: font loader, command, framebuffer, status
// A command walks the cell one glyph scanline at a time: FETCH reads the
// font byte (1-cycle RAM latency), DRAW emits CHAR_W pixels, stalling on
// fb_ready. A font write during a draw aborts it with an err pulse.
// ---------------------------------------------------------------------------
module char_blitter #(
  parameter int PIXEL_WIDTH     = 640,
  parameter int PIXEL_HEIGHT    = 480,
  parameter int SCALE           = 2,
  parameter int FONT_FIRST_CHAR = 32,
  parameter int FONT_NUM_CHARS  = 96,
  parameter int ADDR_W          = 32
) (
  input logic           pclk,
  input logic           rst_n,
  char_blitter_if.slave bus
);
  localparam int CHAR_W     = 8 << (SCALE - 1);
  localparam int CHAR_H     = CHAR_W;
  localparam int COLS       = PIXEL_WIDTH / CHAR_W;
  localparam int ROWS       = PIXEL_HEIGHT / CHAR_H;
  localparam int XY_W       = $clog2(CHAR_W);
  localparam int FONT_DEPTH = FONT_NUM_CHARS * 8;
  localparam int ROW_STRIDE = CHAR_H * PIXEL_WIDTH;
  // Jump from the last pixel of one scanline to the first of the next.
  localparam int ROW_WRAP   = PIXEL_WIDTH - CHAR_W + 1;
  localparam logic [XY_W-1:0] XY_LAST = XY_W'(CHAR_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XY_W-1:0]   x_q, x_d;
  logic [XY_W-1:0]   y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [9:0]        base_q, base_d;
  logic [7:0]        fg_q, fg_d;
  logic [7:0]        bg_q, bg_d;
  logic              transp_q, transp_d;
  logic              err_q, err_d;

  logic [7:0]        font_mem [FONT_DEPTH];
  logic [7:0]        glyph_q;

  logic [9:0]        rd_addr_s;
  logic              rd_en_s;
  logic [2:0]        gsel_s;
  logic              pix_bit_s;
  logic              draw_s;
  logic              wr_s;
  logic              adv_s;
  logic              ready_s;
  logic              bad_cmd_s;
  logic              abort_s;

  // Font RAM: one write port, one registered read port used only in FETCH.
  always_ff @(posedge pclk) begin
    if (bus.font_wr && (int'(bus.font_addr) < FONT_DEPTH)) begin
      font_mem[bus.font_addr] <= bus.font_data;
    end
    if (rd_en_s) begin
      glyph_q <= font_mem[rd_addr_s];
    end
  end

  // Pixel selection, write strobe and command acceptance decode.
  always_comb begin
    rd_en_s   = (state_q == S_FETCH);
    rd_addr_s = base_q + 10'(y_q >> (SCALE - 1));
    gsel_s    = 3'(x_q >> (SCALE - 1));
    pix_bit_s = glyph_q[3'd7 - gsel_s];
    draw_s    = (state_q == S_DRAW);
    // Transparent clear pixels are skipped without a write.
    wr_s      = draw_s && (pix_bit_s || !transp_q);
    adv_s     = draw_s && (!wr_s || bus.fb_ready);
    abort_s   = bus.font_wr && ((state_q == S_FETCH) || (state_q == S_DRAW));
    // DONE also accepts, so back-to-back commands lose no cycle.
    ready_s   = rst_n && ((state_q == S_IDLE) || (state_q == S_DONE)) && !bus.font_wr;
    bad_cmd_s = (int'(bus.cmd_char) < FONT_FIRST_CHAR) ||
                (int'(bus.cmd_char) >= FONT_FIRST_CHAR + FONT_NUM_CHARS) ||
                (int'(bus.cmd_col) >= COLS) ||
                (int'(bus.cmd_row) >= ROWS);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    addr_d   = addr_q;
    base_d   = base_q;
    fg_d     = fg_q;
    bg_d     = bg_q;
    transp_d = transp_q;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.cmd_valid && ready_s) begin
          if (bad_cmd_s) begin
            err_d = 1'b1;
          end else begin
            state_d  = S_FETCH;
            x_d      = '0;
            y_d      = '0;
            // Constant operands: reduces to shifts and adds.
            addr_d   = ADDR_W'(bus.cmd_row) * ADDR_W'(ROW_STRIDE) +
                       ADDR_W'(bus.cmd_col) * ADDR_W'(CHAR_W);
            base_d   = 10'((int'(bus.cmd_char) - FONT_FIRST_CHAR) * 8);
            fg_d     = bus.cmd_fg;
            bg_d     = bus.cmd_bg;
            transp_d = bus.cmd_transparent;
          end
        end else begin
          err_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (abort_s) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        if (abort_s) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (adv_s) begin
          x_d = x_q + XY_W'(1);
          if (x_q == XY_LAST) begin
            addr_d = addr_q + ADDR_W'(ROW_WRAP);
            if (y_q == XY_LAST) begin
              state_d = S_DONE;
            end else begin
              y_d     = y_q + XY_W'(1);
              state_d = S_FETCH;
            end
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end else begin
          state_d = S_DRAW;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      addr_q   <= '0;
      base_q   <= 10'd0;
      fg_q     <= 8'd0;
      bg_q     <= 8'd0;
      transp_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      addr_q   <= addr_d;
      base_q   <= base_d;
      fg_q     <= fg_d;
      bg_q     <= bg_d;
      transp_q <= transp_d;
      err_q    <= err_d;
    end
  end

  // Outputs derive from registered state, so they hold while fb_ready is low.
  assign bus.cmd_ready = ready_s;
  assign bus.fb_wr     = wr_s;
  assign bus.fb_addr   = addr_q;
  assign bus.fb_data   = draw_s ? (pix_bit_s ? fg_q : bg_q) : 8'd0;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.err       = err_q;
endmodule
